// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the issue-entry bundle.
// Both the ALU and the execute-issue stage import this package.
package alu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned REG_W  = 5;

  // ALU opcode encoding, ADD..JALR occupying 00000..01101.
  localparam logic [OP_W-1:0] OP_ADD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b00001;
  localparam logic [OP_W-1:0] OP_SLL   = 5'b00010;
  localparam logic [OP_W-1:0] OP_SLT   = 5'b00011;
  localparam logic [OP_W-1:0] OP_SLTU  = 5'b00100;
  localparam logic [OP_W-1:0] OP_XOR   = 5'b00101;
  localparam logic [OP_W-1:0] OP_SRL   = 5'b00110;
  localparam logic [OP_W-1:0] OP_SRA   = 5'b00111;
  localparam logic [OP_W-1:0] OP_OR    = 5'b01000;
  localparam logic [OP_W-1:0] OP_AND   = 5'b01001;
  localparam logic [OP_W-1:0] OP_LUI   = 5'b01010;
  localparam logic [OP_W-1:0] OP_AUIPC = 5'b01011;
  localparam logic [OP_W-1:0] OP_JAL   = 5'b01100;
  localparam logic [OP_W-1:0] OP_JALR  = 5'b01101;

  // Highest legal opcode; anything above is treated as illegal.
  localparam logic [OP_W-1:0] OP_LAST  = OP_JALR;

  // One issued instruction as it sits in the main or skid slot.
  typedef struct packed {
    logic [XLEN-1:0]  src0;
    logic [XLEN-1:0]  src1;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] rd;
    logic             we;
    logic             illegal;
  } entry_t;

  // True for opcodes whose operand A is always the PC.
  function automatic logic op_uses_pc(input logic [OP_W-1:0] op);
    return (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/ex_issue_if.sv
// Decode-to-ALU bus of the execute-issue stage.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// 1. The sender holds its payload stable while valid && !ready; the receiver
// may raise or lower ready freely. Here in_valid/in_ready is decode -> issue
// and out_valid/out_ready is issue -> ALU. flush is a one-cycle drop-all pulse.
interface ex_issue_if;
  import alu_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [XLEN-1:0]  in_imm;
  logic             in_src0_sel;
  logic             in_src1_sel;
  logic [OP_W-1:0]  in_op;
  logic [REG_W-1:0] in_rd;
  logic             in_we;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  alu_src0;
  logic [XLEN-1:0]  alu_src1;
  logic [OP_W-1:0]  alu_op;
  logic [REG_W-1:0] out_rd;
  logic             out_we;
  logic             out_illegal;

  // The issue stage itself.
  modport slave (
    input  flush, in_valid, in_pc, in_rs1, in_rs2, in_imm,
           in_src0_sel, in_src1_sel, in_op, in_rd, in_we, out_ready,
    output in_ready, out_valid, alu_src0, alu_src1, alu_op,
           out_rd, out_we, out_illegal
  );

  // The surrounding pipeline (decode on one side, ALU on the other).
  modport master (
    output flush, in_valid, in_pc, in_rs1, in_rs2, in_imm,
           in_src0_sel, in_src1_sel, in_op, in_rd, in_we, out_ready,
    input  in_ready, out_valid, alu_src0, alu_src1, alu_op,
           out_rd, out_we, out_illegal
  );

endinterface

// File: rtl/ex_operand_sel.sv
// Combinational operand selection for the issue stage: source muxing,
// PC/zero overrides for AUIPC/JAL/JALR/LUI, and the illegal-opcode squash.
module ex_operand_sel
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  imm,
  input  logic             src0_sel,
  input  logic             src1_sel,
  input  logic [OP_W-1:0]  op,
  input  logic [REG_W-1:0] rd,
  input  logic             we,
  output entry_t           entry
);

  logic illegal;

  assign illegal = (op > OP_LAST);

  // Build the entry bundle; overrides take precedence over the select bits.
  always_comb begin
    entry = '0;
    entry.src0 = src0_sel ? pc : rs1;
    if (op_uses_pc(op)) begin
      entry.src0 = pc;
    end
    if (op == OP_LUI) begin
      entry.src0 = '0;
    end
    entry.src1    = src1_sel ? imm : rs2;
    // Illegal entries still flow, but as a harmless ADD that never writes back.
    entry.op      = illegal ? OP_ADD : op;
    entry.rd      = rd;
    entry.we      = we && !illegal;
    entry.illegal = illegal;
  end

endmodule

// File: rtl/ex_issue.sv
// Execute-issue stage: registers the selected ALU operands into a main slot
// that drives the ALU, backed by a skid slot so one extra entry can be taken
// while a downstream stall is still reaching decode.
module ex_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  ex_issue_if.slave   bus
);

  entry_t new_entry;
  entry_t main_q;
  entry_t skid_q;
  logic   main_valid_q;
  logic   skid_valid_q;
  logic   in_ready_q;
  logic   accept;
  logic   emit;

  ex_operand_sel u_operand_sel (
    .pc       (bus.in_pc),
    .rs1      (bus.in_rs1),
    .rs2      (bus.in_rs2),
    .imm      (bus.in_imm),
    .src0_sel (bus.in_src0_sel),
    .src1_sel (bus.in_src1_sel),
    .op       (bus.in_op),
    .rd       (bus.in_rd),
    .we       (bus.in_we),
    .entry    (new_entry)
  );

  // in_ready comes straight from a flop, so out_ready never reaches it
  // combinationally.
  assign accept = bus.in_valid && in_ready_q;
  assign emit   = main_valid_q && bus.out_ready;

  // Slot control: flush beats everything; otherwise fill main, spill into
  // skid when main is stalled, and promote skid when main drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (bus.flush) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else if (emit) begin
      if (skid_valid_q) begin
        // in_ready was low, so nothing can be accepted this cycle.
        main_q       <= skid_q;
        skid_q       <= '0;
        skid_valid_q <= 1'b0;
        in_ready_q   <= 1'b1;
      end else if (accept) begin
        main_q       <= new_entry;
      end else begin
        main_q       <= '0;
        main_valid_q <= 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_q       <= new_entry;
        skid_valid_q <= 1'b1;
        in_ready_q   <= 1'b0;
      end else begin
        main_q       <= new_entry;
        main_valid_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.alu_src0    = main_q.src0;
  assign bus.alu_src1    = main_q.src1;
  assign bus.alu_op      = main_q.op;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_we      = main_q.we;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_ex_issue.sv
// Directed bench for ex_issue: streaming, stall/skid, LUI, illegal opcode,
// flush and asynchronous reset, with hand-computed expected values.
module tb_ex_issue;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ex_issue_if bus ();

  ex_issue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison point: every check goes through this immediate assertion.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one instruction onto the input side.
  task automatic drive(input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic s0, input logic s1, input logic [4:0] op,
                       input logic [4:0] rd, input logic we);
    bus.in_valid    = 1'b1;
    bus.in_pc       = pc;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_imm      = imm;
    bus.in_src0_sel = s0;
    bus.in_src1_sel = s1;
    bus.in_op       = op;
    bus.in_rd       = rd;
    bus.in_we       = we;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // Check the full output entry against expected values.
  task automatic check_out(input string tag, input logic v, input logic [31:0] s0,
                           input logic [31:0] s1, input logic [4:0] op,
                           input logic [4:0] rd, input logic we, input logic ill);
    check({tag, ".out_valid"},   32'(bus.out_valid),   32'(v));
    check({tag, ".alu_src0"},    bus.alu_src0,         s0);
    check({tag, ".alu_src1"},    bus.alu_src1,         s1);
    check({tag, ".alu_op"},      32'(bus.alu_op),      32'(op));
    check({tag, ".out_rd"},      32'(bus.out_rd),      32'(rd));
    check({tag, ".out_we"},      32'(bus.out_we),      32'(we));
    check({tag, ".out_illegal"}, 32'(bus.out_illegal), 32'(ill));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_pc = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    bus.in_src0_sel = 1'b0; bus.in_src1_sel = 1'b0;
    bus.in_op = '0; bus.in_rd = '0; bus.in_we = 1'b0;
    idle();

    // Reset state.
    #12;
    check_out("reset", 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Streaming: ADD then AUIPC back-to-back with out_ready=1.
    drive(32'h0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, OP_ADD, 5'd1, 1'b1);
    tick();
    check_out("stream_add", 1'b1, 32'd5, 32'd7, 5'b00000, 5'd1, 1'b1, 1'b0);
    drive(32'h100, 32'h55, 32'h66, 32'h2000, 1'b0, 1'b1, OP_AUIPC, 5'd2, 1'b1);
    tick();
    check_out("stream_auipc", 1'b1, 32'h100, 32'h2000, 5'b01011, 5'd2, 1'b1, 1'b0);
    check("stream.in_ready", 32'(bus.in_ready), 32'd1);
    idle();
    tick();
    check("stream_drain.out_valid", 32'(bus.out_valid), 32'd0);

    // Stall: LUI into main, SUB into skid while out_ready=0.
    bus.out_ready = 1'b0;
    drive(32'h40, 32'hDEAD, 32'h0, 32'h12345000, 1'b0, 1'b1, OP_LUI, 5'd3, 1'b1);
    tick();
    check_out("stall_lui", 1'b1, 32'h0, 32'h12345000, 5'b01010, 5'd3, 1'b1, 1'b0);
    check("stall_lui.in_ready", 32'(bus.in_ready), 32'd1);
    drive(32'h44, 32'd20, 32'd3, 32'h0, 1'b0, 1'b0, OP_SUB, 5'd4, 1'b1);
    tick();
    check("stall_skid.in_ready", 32'(bus.in_ready), 32'd0);
    check_out("stall_hold1", 1'b1, 32'h0, 32'h12345000, 5'b01010, 5'd3, 1'b1, 1'b0);
    // A third entry offered while full must not be taken.
    drive(32'h48, 32'd99, 32'd98, 32'h0, 1'b0, 1'b0, OP_XOR, 5'd9, 1'b1);
    tick();
    check_out("stall_hold2", 1'b1, 32'h0, 32'h12345000, 5'b01010, 5'd3, 1'b1, 1'b0);
    check("stall_hold2.in_ready", 32'(bus.in_ready), 32'd0);
    idle();
    bus.out_ready = 1'b1;
    tick();
    check_out("drain_sub", 1'b1, 32'd20, 32'd3, 5'b00001, 5'd4, 1'b1, 1'b0);
    check("drain_sub.in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("drain_empty.out_valid", 32'(bus.out_valid), 32'd0);
    check("drain_empty.in_ready", 32'(bus.in_ready), 32'd1);

    // Illegal opcode with we=1.
    drive(32'h80, 32'd9, 32'd4, 32'h0, 1'b0, 1'b0, 5'b11111, 5'd5, 1'b1);
    tick();
    check_out("illegal", 1'b1, 32'd9, 32'd4, 5'b00000, 5'd5, 1'b0, 1'b1);
    // First opcode past JALR is also illegal; JALR itself is legal and uses PC.
    drive(32'h84, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 5'b01110, 5'd6, 1'b1);
    tick();
    check_out("illegal_edge", 1'b1, 32'd1, 32'd2, 5'b00000, 5'd6, 1'b0, 1'b1);
    drive(32'h88, 32'd1, 32'd2, 32'h10, 1'b0, 1'b1, OP_JALR, 5'd7, 1'b1);
    tick();
    check_out("jalr", 1'b1, 32'h88, 32'h10, 5'b01101, 5'd7, 1'b1, 1'b0);
    idle();
    tick();

    // Flush with occupancy 2 plus a simultaneous in_valid.
    bus.out_ready = 1'b0;
    drive(32'h0, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, OP_ADD, 5'd10, 1'b1);
    tick();
    drive(32'h0, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0, OP_ADD, 5'd11, 1'b1);
    tick();
    check("flush_pre.in_ready", 32'(bus.in_ready), 32'd0);
    drive(32'h0, 32'd100, 32'd200, 32'h0, 1'b0, 1'b0, OP_ADD, 5'd12, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    check_out("flush2", 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("flush2.in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    tick();
    check("flush2_after.out_valid", 32'(bus.out_valid), 32'd0);

    // Flush with occupancy 1 while in_ready=1: the offered input is dropped.
    bus.out_ready = 1'b0;
    drive(32'h0, 32'd7, 32'd8, 32'h0, 1'b0, 1'b0, OP_OR, 5'd13, 1'b1);
    tick();
    drive(32'h0, 32'd50, 32'd60, 32'h0, 1'b0, 1'b0, OP_AND, 5'd14, 1'b1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    idle();
    check_out("flush1", 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check("flush1_after.out_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset with occupancy 2.
    bus.out_ready = 1'b0;
    drive(32'h0, 32'd11, 32'd12, 32'h0, 1'b0, 1'b0, OP_SLT, 5'd15, 1'b1);
    tick();
    drive(32'h0, 32'd13, 32'd14, 32'h0, 1'b0, 1'b0, OP_SLL, 5'd16, 1'b1);
    tick();
    idle();
    check("prerst.in_ready", 32'(bus.in_ready), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("async_rst.in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Normal operation resumes; nothing from before reset reappears.
    drive(32'h0, 32'd21, 32'd22, 32'h0, 1'b0, 1'b0, OP_SRA, 5'd17, 1'b1);
    tick();
    check_out("post_rst", 1'b1, 32'd21, 32'd22, 5'b00111, 5'd17, 1'b1, 1'b0);
    idle();
    tick();
    check("post_rst_drain.out_valid", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_issue.md
# ex_issue

Execute-issue stage of the RISC-V core: accepts one decoded instruction per cycle over a valid/ready handshake, selects and registers the two ALU operands and the ALU opcode, and presents them to the ALU through a 2-entry skid buffer. This lets decode keep running while a downstream stall is still propagating. It sits between the register-file read / immediate generator and the ALU. Writeback metadata (rd, write enable) travels alongside the operands.

## Interface
- No parameters. Data width is fixed at 32 bits and the opcode at 5 bits.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  drop all held entries (branch redirect); synchronous effect
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  32  instruction PC
- in_rs1  in  32  rs1 read data
- in_rs2  in  32  rs2 read data
- in_imm  in  32  generated immediate
- in_src0_sel  in  1  0 selects rs1, 1 selects PC
- in_src1_sel  in  1  0 selects rs2, 1 selects imm
- in_op  in  5  ALU opcode (shared encoding ADD=00000 … JALR=01101)
- in_rd  in  5  destination register
- in_we  in  1  register write enable
- out_valid  out  1  alu_src0/alu_src1/alu_op valid
- out_ready  in  1  ALU/next stage consumes this cycle
- alu_src0  out  32  operand A
- alu_src1  out  32  operand B
- alu_op  out  5  opcode to ALU
- out_rd  out  5  destination register
- out_we  out  1  write enable (0 when illegal)
- out_illegal  out  1  opcode was outside 00000..01101

## Operation
- Operand selection happens at acceptance:
  - src0 = sel ? pc : rs1; src1 = sel ? imm : rs2.
  - Overrides: op in {AUIPC, JAL, JALR} forces src0 = pc. op = LUI forces src0 = 0.
- Illegal opcode (greater than 01101): alu_op is forced to ADD, out_illegal=1, out_we=0. The entry still flows through the stage.
- Storage is a main register (drives the outputs) plus a skid register; occupancy is 0..2.
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- Per cycle, with no flush:
  - Accept only, main empty or emitting: the input goes to main.
  - Accept while main is held (not emitting): the input goes to skid.
  - Emit with skid full: skid moves to main.
  - Emit only: main is cleared.
- in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- flush clears main and skid. An in_valid in the same cycle is dropped (flush wins over accept and emit). in_ready is 1 on the next cycle.
- Entries leave in strict acceptance order; no entry is lost or duplicated.

## Timing
- Reset values: out_valid=0, in_ready=1, alu_src0=alu_src1=0, alu_op=00000, out_rd=0, out_we=0, out_illegal=0, both slots empty.
- Reset asserted mid-transfer discards all entries immediately (asynchronously).
- Latency is 1 cycle: input accepted at edge N appears on the outputs after edge N, with out_valid=1 in cycle N+1.
- Throughput is 1 per cycle while out_ready=1.
- A stall at out_ready is absorbed without data loss:
  - The first stalled cycle can still accept one entry (into skid).
  - in_ready falls on the following cycle.
- Outputs hold stable while out_valid && !out_ready.
- With occupancy 2 and out_ready=1: skid moves to main, and in_ready rises the next cycle.

## Structure
- Opcode constants (ADD…JALR, 5-bit) move into a shared package alu_pkg, replacing per-file defines. Both ALU and ex_issue import it.
- alu_pkg also holds the entry bundle struct: src0, src1, op, rd, we, illegal.
- One combinational sub-module, ex_operand_sel, performs operand muxing, the overrides and the illegal check. Its output is the entry bundle.
- Slot control (main/skid registers) stays in ex_issue.

## Test plan
- Streaming, out_ready=1: ADD with rs1=5, rs2=7, sels 0/0, then AUIPC with pc=0x100, imm=0x2000, src0_sel=0 -> cycle 1 gives src0=5, src1=7, op=00000; cycle 2 gives src0=0x100 (forced), src1=0x2000, op=01011.
- Stall: out_ready=0 while two entries are sent back-to-back -> second entry accepted into skid, in_ready=0 the next cycle, outputs held. Raise out_ready -> both entries emitted in order on consecutive cycles, then in_ready=1.
- LUI with rs1=0xDEAD, imm=0x12345000 -> src0=0, src1=0x12345000, op=01010.
- Illegal op 11111 with we=1 -> alu_op=00000, out_illegal=1, out_we=0.
- flush with occupancy 2 plus a simultaneous in_valid -> next cycle out_valid=0, in_ready=1, and the flushed entries and the dropped input never appear on the outputs.
- rst asserted asynchronously mid-stream -> outputs are at reset values immediately, before the next clock edge.
